// File: rtl/imem_port_arbiter_pkg.sv
// Shared types and helpers for the instruction-memory port arbiter.
package imem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IFU,
    S_WAIT_DBG,
    S_DRAIN,
    S_RESP_IFU,
    S_RESP_DBG
  } e_imem_arb_state;

  typedef enum logic {
    ARB_IFU,
    ARB_DBG
  } e_imem_arb_port;

  // Port to grant when at least one requester is a candidate; on a conflict
  // the port that did not win last time goes first.
  function automatic e_imem_arb_port pick_port(input logic           ifu_cand,
                                               input logic           dbg_req,
                                               input e_imem_arb_port last_grant);
    if (ifu_cand && dbg_req) return (last_grant == ARB_IFU) ? ARB_DBG : ARB_IFU;
    if (ifu_cand)            return ARB_IFU;
    return ARB_DBG;
  endfunction

endpackage

// File: rtl/imem_port_arbiter.sv
// Shares the single-ported instruction memory between the IFU fetch port and a
// debug/loader port. One transaction in flight, round-robin on conflicts,
// squashes IFU fetches made stale by a flush, and aborts on a memory timeout.
module imem_port_arbiter
  import imem_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_load_en_i,
  input  logic [DATA_WIDTH-1:0] ifu_load_addr_i,
  output logic                  ifu_load_busy_o,
  output logic                  ifu_load_rdy_o,
  output logic [31:0]           ifu_load_insn_o,
  input  logic                  flush_i,
  input  logic                  dbg_req_i,
  input  logic                  dbg_we_i,
  input  logic [DATA_WIDTH-1:0] dbg_addr_i,
  input  logic [31:0]           dbg_wdata_i,
  output logic                  dbg_gnt_o,
  output logic                  dbg_rvalid_o,
  output logic [31:0]           dbg_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  mem_rvalid_i,
  output logic                  err_o
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  e_imem_arb_state       state_q, state_d;
  e_imem_arb_port        last_grant_q, last_grant_d;
  e_imem_arb_port        pick;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ifu_cand, timeout_hit;

  logic                  mem_req_d, mem_we_d, dbg_gnt_d, ifu_rdy_d, dbg_rvalid_d, err_d;
  logic [DATA_WIDTH-1:0] mem_addr_d;
  logic [31:0]           mem_wdata_d, insn_d, dbg_rdata_d;

  // A flush in the same cycle means the IFU pc is stale, so it cannot win.
  assign ifu_cand    = ifu_load_en_i && !flush_i;
  // Counter holds the number of cycles already spent waiting; this is the last allowed one.
  assign timeout_hit = (cnt_q == CNT_LAST);
  assign pick        = pick_port(ifu_cand, dbg_req_i, last_grant_q);
  // Busy covers RESP_IFU too, so the IFU cannot re-issue its pre-increment pc.
  assign ifu_load_busy_o = (state_q != S_IDLE);

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q + 1'b1;
    mem_req_d    = 1'b0;
    mem_we_d     = mem_we_o;
    mem_addr_d   = mem_addr_o;
    mem_wdata_d  = mem_wdata_o;
    dbg_gnt_d    = 1'b0;
    ifu_rdy_d    = 1'b0;
    dbg_rvalid_d = 1'b0;
    insn_d       = ifu_load_insn_o;
    dbg_rdata_d  = dbg_rdata_o;
    err_d        = err_o;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (ifu_cand || dbg_req_i) begin
          mem_req_d    = 1'b1;
          last_grant_d = pick;
          if (pick == ARB_IFU) begin
            mem_we_d   = 1'b0;
            mem_addr_d = ifu_load_addr_i;
            state_d    = S_WAIT_IFU;
          end else begin
            mem_we_d    = dbg_we_i;
            mem_addr_d  = dbg_addr_i;
            mem_wdata_d = dbg_wdata_i;
            dbg_gnt_d   = 1'b1;
            state_d     = S_WAIT_DBG;
          end
        end
      end
      S_WAIT_IFU: begin
        if (mem_rvalid_i) begin
          if (!flush_i) begin
            insn_d    = mem_rdata_i;
            ifu_rdy_d = 1'b1;
            state_d   = S_RESP_IFU;
          end else begin
            state_d = S_IDLE;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (flush_i) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_rvalid_i) begin
          state_d = S_IDLE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT_DBG: begin
        if (mem_rvalid_i) begin
          dbg_rdata_d  = mem_we_o ? 32'h0 : mem_rdata_i;
          dbg_rvalid_d = 1'b1;
          state_d      = S_RESP_DBG;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RESP_IFU, S_RESP_DBG: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, round-robin pointer, watchdog counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q         <= S_IDLE;
      last_grant_q    <= ARB_DBG;
      cnt_q           <= '0;
      mem_req_o       <= 1'b0;
      mem_we_o        <= 1'b0;
      mem_addr_o      <= '0;
      mem_wdata_o     <= '0;
      dbg_gnt_o       <= 1'b0;
      ifu_load_rdy_o  <= 1'b0;
      dbg_rvalid_o    <= 1'b0;
      ifu_load_insn_o <= '0;
      dbg_rdata_o     <= '0;
      err_o           <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      cnt_q           <= cnt_d;
      mem_req_o       <= mem_req_d;
      mem_we_o        <= mem_we_d;
      mem_addr_o      <= mem_addr_d;
      mem_wdata_o     <= mem_wdata_d;
      dbg_gnt_o       <= dbg_gnt_d;
      ifu_load_rdy_o  <= ifu_rdy_d;
      dbg_rvalid_o    <= dbg_rvalid_d;
      ifu_load_insn_o <= insn_d;
      dbg_rdata_o     <= dbg_rdata_d;
      err_o           <= err_d;
    end
  end

endmodule
